// File: rtl/cyclic74_pkg.sv
// Shared definitions for the (7,4) cyclic-code Meggitt decoder.
// Holds the code geometry, the generator polynomial, the syndrome of an
// error at the first corrected position (x^6 mod g) and the controller
// state encoding.
package cyclic74_pkg;

  localparam int N     = 7;
  localparam int SYN_W = 3;

  // g(x) = x^3 + x + 1, bit i = coefficient of x^i
  localparam logic [3:0] GEN_POLY = 4'b1011;

  // x^6 mod g(x) = x^2 + 1
  localparam logic [SYN_W-1:0] ERR_PATTERN = 3'b101;

  localparam logic [2:0] K_MAX = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CORRECT,
    DONE
  } state_t;

endpackage

// File: rtl/cyclic74_decode_sequencer_if.sv
// Handshake bundle between the deframer, the decoder and the unpacker.
// Signals:
//   in_valid/in_ready/in_word      : received word, one per handshake
//   out_valid/out_ready/out_word   : corrected word, one per handshake
//   out_corrected                  : a single bit was flipped in out_word
//   busy                           : decoder holds a word
//   err_count                      : saturating count of corrected words
// Modports: master = producer/consumer side, slave = decoder side.
interface cyclic74_decode_sequencer_if
  import cyclic74_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_word;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_word;
  logic             out_corrected;
  logic             busy;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_corrected, busy, err_count
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_corrected, busy, err_count
  );

endinterface

// File: rtl/cyclic74_syndrome_reg.sv
// Bit-serial syndrome register: divides the incoming bit stream (MSB first)
// by the generator polynomial, leaving the remainder in syn.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear the syndrome (priority over shift_en)
//   shift_en  : shift one bit in
//   bit_in    : next bit of the dividend
//   syn[2:0]  : current remainder
module cyclic74_syndrome_reg
  import cyclic74_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [SYN_W-1:0] syn
);

  logic fb;

  // The x^3 term falls off the top and folds back as x + 1 via the
  // generator taps.
  assign fb = syn[SYN_W-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      syn <= '0;
    end else if (shift_en) begin
      syn <= {syn[1] ^ (fb & GEN_POLY[2]),
              syn[0] ^ (fb & GEN_POLY[1]),
              bit_in ^ (fb & GEN_POLY[0])};
    end
  end

endmodule

// File: rtl/cyclic74_decode_sequencer.sv
// Meggitt decoder controller for the (7,4) cyclic code.
// A received word is shifted into the syndrome register one bit per clock
// (SHIFT), then the syndrome is rotated while the word is emitted bit by
// bit, flipping the bit whose position brings the syndrome to x^6 mod g
// (CORRECT). The result is held in DONE until the consumer takes it.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of cyclic74_decode_sequencer_if
module cyclic74_decode_sequencer
  import cyclic74_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  cyclic74_decode_sequencer_if.slave   bus
);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       k_q;
  logic [N-1:0]     word_buf;
  logic [N-1:0]     out_word_q;
  logic             out_corr_q;
  logic [CNT_W-1:0] err_count_q;

  logic             syn_clr;
  logic             syn_shift;
  logic             syn_bit;
  logic [SYN_W-1:0] syn;
  logic             err_hit;

  cyclic74_syndrome_reg u_syn (
    .clk      (clk),
    .rst      (rst),
    .clr      (syn_clr),
    .shift_en (syn_shift),
    .bit_in   (syn_bit),
    .syn      (syn)
  );

  // Syndrome equal to x^6 mod g means the bit now at the output is in error.
  assign err_hit = (syn == ERR_PATTERN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    syn_clr   = 1'b0;
    syn_shift = 1'b0;
    syn_bit   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          syn_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        syn_shift = 1'b1;
        syn_bit   = word_buf[k_q];
        if (k_q == 3'd0) state_d = CORRECT;
      end
      CORRECT: begin
        bus.busy = 1'b1;
        // Once the error is fixed the syndrome is zeroed so no further
        // position can match.
        if (err_hit) syn_clr = 1'b1;
        else         syn_shift = 1'b1;
        if (k_q == 3'd0) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: step counter, input buffer, corrected output and the
  // saturating corrected-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= K_MAX;
      word_buf    <= '0;
      out_word_q  <= '0;
      out_corr_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_buf   <= bus.in_word;
            k_q        <= K_MAX;
            out_corr_q <= 1'b0;
          end
        end
        SHIFT: begin
          k_q <= (k_q == 3'd0) ? K_MAX : k_q - 3'd1;
        end
        CORRECT: begin
          out_word_q[k_q] <= word_buf[k_q] ^ err_hit;
          if (err_hit) out_corr_q <= 1'b1;
          k_q <= (k_q == 3'd0) ? K_MAX : k_q - 3'd1;
        end
        DONE: begin
          if (bus.out_ready && out_corr_q && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_word      = out_word_q;
  assign bus.out_corrected = out_corr_q;
  assign bus.err_count     = err_count_q;

endmodule
